// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_pkg
//  Description : Shared AXI4-Lite types: address/data/strobe widths, response
//                codes and the write/read FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [STRB_W-1:0] strb_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_HAVE_ADDR = 2'd1,
    W_HAVE_DATA = 2'd2,
    W_RESP      = 2'd3
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_lite_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_if
//  Description : AXI4-Lite bundle (AW, W, B, AR, R) with master/slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_lite_if;
  import axi_lite_pkg::*;

  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;
  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface
`default_nettype wire

// File: rtl/axi_lite_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_regfile
//  Description : NUM_REGS x 32-bit register bank with a byte-enabled write
//                port, a combinational read port and one-cycle write pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_regfile import axi_lite_pkg::*; #(
  parameter int NUM_REGS    = 8,
  parameter bit IGNORE_STRB = 1'b1,
  localparam int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  data_t               wdata,
  input  strb_t               wstrb,
  input  logic [IDX_W-1:0]    raddr,
  output data_t               rdata,
  output data_t               regs_q [NUM_REGS],
  output logic [NUM_REGS-1:0] wr_pulse
);

  data_t               regs_d [NUM_REGS];
  data_t               byte_mask;
  logic [NUM_REGS-1:0] wr_pulse_d;
  logic [NUM_REGS-1:0] wr_pulse_q;

  // Expand strobes to a bit mask; strobes are don't-care when IGNORE_STRB is set
  for (genvar i = 0; i < STRB_W; i++) begin : g_byte_mask
    assign byte_mask[8*i +: 8] = (IGNORE_STRB || wstrb[i]) ? 8'hFF : 8'h00;
  end

  // Next register contents and the pulse that marks which register was committed
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    wr_pulse_d = '0;
    if (we) begin
      regs_d[waddr]     = (regs_q[waddr] & ~byte_mask) | (wdata & byte_mask);
      wr_pulse_d[waddr] = 1'b1;
    end
  end

  // Storage and pulse flops
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_pulse_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Read port sees pre-commit contents, so a same-edge read returns the old value
  assign rdata    = regs_q[raddr];
  assign wr_pulse = wr_pulse_q;

endmodule
`default_nettype wire

// File: rtl/axi_lite_slave_regs.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_slave_regs
//  Description : AXI4-Lite slave exposing a bank of 32-bit registers. Holds
//                the independent write and read FSMs and the address decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_slave_regs import axi_lite_pkg::*; #(
  parameter addr_t BASE_ADDR   = 12'h000,
  parameter int    NUM_REGS    = 8,
  parameter bit    IGNORE_STRB = 1'b1
) (
  input  logic                aclk,
  input  logic                areset,
  axi_lite_if.slave           s_axi_lite,
  output data_t               regs_q [NUM_REGS],
  output logic [NUM_REGS-1:0] wr_pulse
);

  localparam int IDX_W = $clog2(NUM_REGS);
  // Extra bit keeps BASE_ADDR + span from wrapping at the top of the map
  localparam logic [ADDR_W:0] REG_SPAN = (ADDR_W + 1)'(4 * NUM_REGS);

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;
  addr_t     awaddr_q, awaddr_d;
  data_t     wdata_q, wdata_d;
  strb_t     wstrb_q, wstrb_d;
  resp_t     bresp_q, bresp_d;
  data_t     rdata_q, rdata_d;
  resp_t     rresp_q, rresp_d;

  logic        aw_hs, w_hs, ar_hs, wr_commit;
  addr_t       wr_addr;
  data_t       wr_data;
  strb_t       wr_strb;
  logic [ADDR_W:0] wr_off, rd_off;
  logic        wr_hit, rd_hit;
  data_t       rf_rdata;

  // Address decode: the commit address comes from the latch once AW was taken early
  always_comb begin
    wr_addr = (wr_state_q == W_HAVE_ADDR) ? awaddr_q : s_axi_lite.awaddr;
    wr_data = (wr_state_q == W_HAVE_DATA) ? wdata_q  : s_axi_lite.wdata;
    wr_strb = (wr_state_q == W_HAVE_DATA) ? wstrb_q  : s_axi_lite.wstrb;
    wr_off  = {1'b0, wr_addr} - {1'b0, BASE_ADDR};
    rd_off  = {1'b0, s_axi_lite.araddr} - {1'b0, BASE_ADDR};
    wr_hit  = (wr_addr >= BASE_ADDR) && (wr_off < REG_SPAN);
    rd_hit  = (s_axi_lite.araddr >= BASE_ADDR) && (rd_off < REG_SPAN);
  end

  // State registers for both FSMs and their latched channel data
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Write FSM next state: collect AW and W in either order, then respond on B
  always_comb begin
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    wr_commit  = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_commit = 1'b1;
        end else if (aw_hs) begin
          awaddr_d   = s_axi_lite.awaddr;
          wr_state_d = W_HAVE_ADDR;
        end else if (w_hs) begin
          wdata_d    = s_axi_lite.wdata;
          wstrb_d    = s_axi_lite.wstrb;
          wr_state_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: wr_commit = w_hs;
      W_HAVE_DATA: wr_commit = aw_hs;
      W_RESP: begin
        if (s_axi_lite.bready) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    if (wr_commit) begin
      wr_state_d = W_RESP;
      bresp_d    = wr_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read FSM next state: capture data on the AR handshake, hold it until R completes
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_state_d = R_DATA;
          rdata_d    = rd_hit ? rf_rdata : '0;
          rresp_d    = rd_hit ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (s_axi_lite.rready) begin
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Channel outputs: readies depend only on state (and are held low in reset)
  always_comb begin
    s_axi_lite.awready = !areset && ((wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_DATA));
    s_axi_lite.wready  = !areset && ((wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_ADDR));
    s_axi_lite.bvalid  = (wr_state_q == W_RESP);
    s_axi_lite.bresp   = bresp_q;
    s_axi_lite.arready = !areset && (rd_state_q == R_IDLE);
    s_axi_lite.rvalid  = (rd_state_q == R_DATA);
    s_axi_lite.rdata   = rdata_q;
    s_axi_lite.rresp   = rresp_q;
    aw_hs = s_axi_lite.awvalid && s_axi_lite.awready;
    w_hs  = s_axi_lite.wvalid  && s_axi_lite.wready;
    ar_hs = s_axi_lite.arvalid && s_axi_lite.arready;
  end

  axi_lite_regfile #(
    .NUM_REGS    (NUM_REGS),
    .IGNORE_STRB (IGNORE_STRB)
  ) u_regfile (
    .clk      (aclk),
    .rst      (areset),
    .we       (wr_commit && wr_hit),
    .waddr    (wr_off[IDX_W+1:2]),
    .wdata    (wr_data),
    .wstrb    (wr_strb),
    .raddr    (rd_off[IDX_W+1:2]),
    .rdata    (rf_rdata),
    .regs_q   (regs_q),
    .wr_pulse (wr_pulse)
  );

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slave_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_slave_regs
//  Description : Self-checking bench for axi_lite_slave_regs. Two instances
//                (IGNORE_STRB=1 and 0) share one master stimulus stream and
//                are compared every cycle against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_slave_regs;
  import axi_lite_pkg::*;

  localparam int NREG = 8;
  localparam int BASE = 0;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  axi_lite_if bus ();
  axi_lite_if bus_s ();

  data_t               regs0 [NREG];
  data_t               regs1 [NREG];
  logic [NREG-1:0]     pulse0, pulse1;

  axi_lite_slave_regs #(.BASE_ADDR(12'h000), .NUM_REGS(NREG), .IGNORE_STRB(1'b1)) dut (
    .aclk(aclk), .areset(areset), .s_axi_lite(bus), .regs_q(regs0), .wr_pulse(pulse0));

  axi_lite_slave_regs #(.BASE_ADDR(12'h000), .NUM_REGS(NREG), .IGNORE_STRB(1'b0)) dut_s (
    .aclk(aclk), .areset(areset), .s_axi_lite(bus_s), .regs_q(regs1), .wr_pulse(pulse1));

  // Second instance sees exactly the same master activity
  assign bus_s.awaddr  = bus.awaddr;
  assign bus_s.awvalid = bus.awvalid;
  assign bus_s.wdata   = bus.wdata;
  assign bus_s.wstrb   = bus.wstrb;
  assign bus_s.wvalid  = bus.wvalid;
  assign bus_s.bready  = bus.bready;
  assign bus_s.araddr  = bus.araddr;
  assign bus_s.arvalid = bus.arvalid;
  assign bus_s.rready  = bus.rready;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int pulse_cnt [NREG];

  // ---------------- transaction-level reference model ----------------
  // Index 0 models IGNORE_STRB=1, index 1 models IGNORE_STRB=0.
  data_t       m_regs [2][NREG];
  data_t       m_rdata [2];
  bit          m_aw_pend, m_w_pend, m_bvalid, m_rvalid;
  addr_t       m_awaddr;
  data_t       m_wdata;
  strb_t       m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic [NREG-1:0] m_pulse;

  task automatic model_step();
    bit aw_t, w_t, ar_t, hit;
    int ia, idx;
    if (areset) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < NREG; i++) m_regs[k][i] = '0;
        m_rdata[k] = '0;
      end
      m_aw_pend = 0; m_w_pend = 0; m_bvalid = 0; m_rvalid = 0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_pulse = '0;
      return;
    end
    aw_t = bus.awvalid && !m_aw_pend && !m_bvalid;
    w_t  = bus.wvalid  && !m_w_pend  && !m_bvalid;
    ar_t = bus.arvalid && !m_rvalid;
    m_pulse = '0;
    // read sees contents before any write committing on this edge
    if (m_rvalid && bus.rready) m_rvalid = 0;
    if (ar_t) begin
      ia  = int'(bus.araddr);
      hit = (ia >= BASE) && (ia < BASE + 4 * NREG);
      idx = (ia - BASE) / 4;
      for (int k = 0; k < 2; k++) m_rdata[k] = hit ? m_regs[k][idx] : 32'h0;
      m_rresp  = hit ? 2'b00 : 2'b10;
      m_rvalid = 1;
    end
    if (m_bvalid && bus.bready) m_bvalid = 0;
    if (aw_t) begin m_aw_pend = 1; m_awaddr = bus.awaddr; end
    if (w_t)  begin m_w_pend = 1; m_wdata = bus.wdata; m_wstrb = bus.wstrb; end
    if (m_aw_pend && m_w_pend) begin
      ia  = int'(m_awaddr);
      hit = (ia >= BASE) && (ia < BASE + 4 * NREG);
      idx = (ia - BASE) / 4;
      if (hit) begin
        m_regs[0][idx] = m_wdata;
        for (int b = 0; b < 4; b++)
          if (m_wstrb[b]) m_regs[1][idx][8*b +: 8] = m_wdata[8*b +: 8];
        m_pulse[idx] = 1'b1;
      end
      m_bresp   = hit ? 2'b00 : 2'b10;
      m_bvalid  = 1;
      m_aw_pend = 0;
      m_w_pend  = 0;
    end
  endtask

  initial forever begin
    @(posedge aclk);
    model_step();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  task automatic compare();
    logic e_aw, e_w, e_ar;
    e_aw = !areset && !m_aw_pend && !m_bvalid;
    e_w  = !areset && !m_w_pend  && !m_bvalid;
    e_ar = !areset && !m_rvalid;
    chk("awready", bus.awready, e_aw);   chk("awready_s", bus_s.awready, e_aw);
    chk("wready",  bus.wready,  e_w);    chk("wready_s",  bus_s.wready,  e_w);
    chk("arready", bus.arready, e_ar);   chk("arready_s", bus_s.arready, e_ar);
    chk("bvalid",  bus.bvalid,  m_bvalid); chk("bvalid_s", bus_s.bvalid, m_bvalid);
    chk("bresp",   bus.bresp,   m_bresp);  chk("bresp_s",  bus_s.bresp,  m_bresp);
    chk("rvalid",  bus.rvalid,  m_rvalid); chk("rvalid_s", bus_s.rvalid, m_rvalid);
    chk("rresp",   bus.rresp,   m_rresp);  chk("rresp_s",  bus_s.rresp,  m_rresp);
    chk("rdata",   bus.rdata,   m_rdata[0]); chk("rdata_s", bus_s.rdata, m_rdata[1]);
    chk("wr_pulse",   pulse0, m_pulse);
    chk("wr_pulse_s", pulse1, m_pulse);
    for (int i = 0; i < NREG; i++) begin
      chk($sformatf("regs[%0d]", i),   regs0[i], m_regs[0][i]);
      chk($sformatf("regs_s[%0d]", i), regs1[i], m_regs[1][i]);
      if (pulse0[i]) pulse_cnt[i]++;
    end
  endtask

  initial forever begin
    @(negedge aclk);
    if (chk_en) compare();
  end

  // ---------------- master-side drivers ----------------
  // aw_start/w_start: cycle each channel goes valid; b_hold: cycles bready stays low after bvalid
  task automatic do_write(input addr_t a, input data_t d, input strb_t s, input int aw_start,
                          input int w_start, input int b_hold, output logic [1:0] rsp, output bit ok);
    int cyc = 0;
    int b_seen = -1;
    bit aw_done = 0, w_done = 0, b_done = 0;
    rsp = 2'bxx;
    while (!b_done && cyc < 64) begin
      bus.awaddr  = a;
      bus.wdata   = d;
      bus.wstrb   = s;
      bus.awvalid = !aw_done && (cyc >= aw_start);
      bus.wvalid  = !w_done && (cyc >= w_start);
      bus.bready  = (b_hold == 0) || (b_seen >= 0 && cyc - b_seen >= b_hold);
      @(negedge aclk);
      if (bus.awvalid && bus.awready) aw_done = 1;
      if (bus.wvalid && bus.wready) w_done = 1;
      if (bus.bvalid) begin
        if (b_seen < 0) b_seen = cyc;
        if (bus.bready) begin b_done = 1; rsp = bus.bresp; end
      end
      @(posedge aclk); #1;
      cyc++;
    end
    bus.awvalid = 0; bus.wvalid = 0; bus.bready = 0;
    ok = b_done;
    if (!ok) chk("write_timeout", {31'b0, b_done}, 32'd1);
  endtask

  task automatic do_read(input addr_t a, input int r_hold, output data_t d,
                         output logic [1:0] rsp, output bit ok);
    int cyc = 0;
    int r_seen = -1;
    bit ar_done = 0, r_done = 0;
    d = 'x; rsp = 2'bxx;
    while (!r_done && cyc < 64) begin
      bus.araddr  = a;
      bus.arvalid = !ar_done;
      bus.rready  = (r_hold == 0) || (r_seen >= 0 && cyc - r_seen >= r_hold);
      @(negedge aclk);
      if (bus.arvalid && bus.arready) ar_done = 1;
      if (bus.rvalid) begin
        if (r_seen < 0) r_seen = cyc;
        if (bus.rready) begin r_done = 1; d = bus.rdata; rsp = bus.rresp; end
      end
      @(posedge aclk); #1;
      cyc++;
    end
    bus.arvalid = 0; bus.rready = 0;
    ok = r_done;
    if (!ok) chk("read_timeout", {31'b0, r_done}, 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [1:0] wr_rsp, rd_rsp;
    data_t      rd_d;
    bit         ok, hs;
    int         psum, k;

    areset = 1'b1;
    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
    bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
    for (int i = 0; i < NREG; i++) pulse_cnt[i] = 0;
    @(posedge aclk); #1;
    chk_en = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("rst_awready_low", bus.awready, 1'b0);
    chk("rst_bvalid_low",  bus.bvalid,  1'b0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("post_rst_awready", bus.awready, 1'b1);
    chk("post_rst_regs1",   regs0[1],    32'h0);
    @(posedge aclk); #1;

    // AW one cycle ahead of W, bready high throughout, strobes all zero
    do_write(12'h004, 32'hA5A5_0001, 4'b0000, 0, 1, 0, wr_rsp, ok);
    chk("w1_bresp", wr_rsp, 2'b00);
    chk("w1_regs1", regs0[1], 32'hA5A5_0001);
    chk("w1_regs1_strb0", regs1[1], 32'h0);
    chk("w1_model", m_regs[0][1], 32'hA5A5_0001);
    chk("w1_pulse_cnt", pulse_cnt[1], 1);

    // W three cycles ahead of AW, slow bready
    do_write(12'h008, 32'h1234_5678, 4'hF, 3, 0, 4, wr_rsp, ok);
    chk("w2_bresp", wr_rsp, 2'b00);
    chk("w2_regs2", regs0[2], 32'h1234_5678);

    do_read(12'h004, 2, rd_d, rd_rsp, ok);
    chk("r1_rdata", rd_d, 32'hA5A5_0001);
    chk("r1_rresp", rd_rsp, 2'b00);

    // Out-of-range write and read
    psum = 0;
    for (int i = 0; i < NREG; i++) psum += pulse_cnt[i];
    do_write(12'h040, 32'hCAFE_F00D, 4'hF, 0, 0, 0, wr_rsp, ok);
    chk("oor_bresp", wr_rsp, 2'b10);
    k = 0;
    for (int i = 0; i < NREG; i++) k += pulse_cnt[i];
    chk("oor_no_pulse", k, psum);
    do_read(12'h040, 0, rd_d, rd_rsp, ok);
    chk("oor_rdata", rd_d, 32'h0);
    chk("oor_rresp", rd_rsp, 2'b10);

    // Read captured on the same edge as a write commit returns the old value
    fork
      do_write(12'h004, 32'hFFFF_0000, 4'hF, 0, 0, 0, wr_rsp, ok);
      do_read(12'h004, 0, rd_d, rd_rsp, ok);
    join
    chk("same_edge_old", rd_d, 32'hA5A5_0001);
    do_read(12'h004, 0, rd_d, rd_rsp, ok);
    chk("same_edge_new", rd_d, 32'hFFFF_0000);

    // Partial strobes matter only on the IGNORE_STRB=0 instance
    do_write(12'h00C, 32'hDEAD_BEEF, 4'b0011, 0, 0, 0, wr_rsp, ok);
    chk("strb_ignored", regs0[3], 32'hDEAD_BEEF);
    chk("strb_applied", regs1[3], 32'h0000_BEEF);
    chk("strb_model", m_regs[1][3], 32'h0000_BEEF);

    // Reset while holding an address with no data: transaction is abandoned
    bus.awaddr = 12'h010; bus.awvalid = 1'b1;
    k = 0;
    do begin
      @(negedge aclk);
      hs = bus.awready;
      @(posedge aclk); #1;
      k++;
    end while (!hs && k < 10);
    chk("mid_aw_taken", hs, 1'b1);
    bus.awvalid = 1'b0;
    areset = 1'b1;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    areset = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      chk("mid_rst_no_bvalid", bus.bvalid, 1'b0);
    end
    for (int i = 0; i < NREG; i++) chk("mid_rst_regs", regs0[i] | regs1[i], 32'h0);
    @(posedge aclk); #1;

    // Random concurrent traffic, including unaligned and out-of-range addresses
    fork
      begin : rnd_wr
        logic [1:0] rw; bit okw;
        for (int n = 0; n < 150; n++)
          do_write(addr_t'($urandom_range(0, 12'h05F)), $urandom, strb_t'($urandom_range(0, 15)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), rw, okw);
      end
      begin : rnd_rd
        logic [1:0] rr; data_t dr; bit okr;
        for (int n = 0; n < 150; n++) begin
          do_read(addr_t'($urandom_range(0, 12'h05F)), $urandom_range(0, 2), dr, rr, okr);
          repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
        end
      end
    join

    repeat (2) @(posedge aclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
